// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the mem_access_unit load/store sequencer.
//   - request size encodings (SZ_BYTE / SZ_HALF / SZ_WORD, 2'b11 behaves as word)
//   - sequencer state enum
//   - size_bytes(): number of single-byte memory cycles for a request size
//   - is_misaligned(): alignment test used when MISALIGN_TRAP_EN is defined
package proce_mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      CAPTURE,
      DONE
   } state_t;

   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         SZ_BYTE: return 3'd1;
         SZ_HALF: return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return addr_lo[0];
         default: return (addr_lo != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Bus bundle between the execute/memory pipeline stage, mem_access_unit and
// the byte-wide data memory.
//   Request  : req_valid, req_ready, req_we, req_size, req_signed, req_addr, req_wdata
//   Response : resp_valid, resp_rdata, resp_err
//   Memory   : MemoryAddress, memRD, memWD, mem_wdata, mem_rdata
// modport slave  : the sequencer (consumes requests, drives the memory strobes)
// modport master : the environment (pipeline stage plus the memory itself)
interface mem_access_unit_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_signed;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;
   logic [ADDR_W-1:0] MemoryAddress;
   logic              memRD;
   logic              memWD;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
             MemoryAddress, memRD, memWD, mem_wdata
   );

   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
             MemoryAddress, memRD, memWD, mem_wdata
   );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// load_extend: combinational sign/zero extension of the assembled load word.
//   word      in  assembled little-endian load data
//   size      in  request size (byte / half / word, 2'b11 as word)
//   is_signed in  1 = sign-extend byte (bit 7) or half (bit 15)
//   ext       out extended result; word loads pass through unchanged
module load_extend
   import proce_mem_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] word,
   input  logic [1:0]        size,
   input  logic              is_signed,
   output logic [DATA_W-1:0] ext
);

   always_comb begin
      ext = word;
      case (size)
         SZ_BYTE: ext = is_signed ? {{(DATA_W-8){word[7]}}, word[7:0]}
                                  : {{(DATA_W-8){1'b0}}, word[7:0]};
         SZ_HALF: ext = is_signed ? {{(DATA_W-16){word[15]}}, word[15:0]}
                                  : {{(DATA_W-16){1'b0}}, word[15:0]};
         default: ext = word;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer in front of a byte-addressed data
// memory with a registered read port. Each byte/half/word request is split
// into single-byte little-endian memory cycles; load bytes are reassembled,
// extended by load_extend and returned with a one-cycle resp_valid pulse.
//   clk, Reset : single clock, synchronous active-high reset
//   bus        : mem_access_unit_if.slave (request, response and memory signals)
// Optional build macro MISALIGN_TRAP_EN: misaligned half/word requests skip
// the memory entirely and complete with resp_err=1, resp_rdata=0.
module mem_access_unit
   import proce_mem_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LANE_W = 8
) (
   input logic              clk,
   input logic              Reset,
   mem_access_unit_if.slave bus
);

   state_t            state, state_nxt;
   logic [2:0]        idx;
   logic [ADDR_W-1:0] addr_r;
   logic [1:0]        size_r;
   logic              signed_r;
   logic              we_r;
   logic [DATA_W-1:0] wdata_r;
   logic [DATA_W-1:0] asm_r;
   logic [DATA_W-1:0] ext_data;
   logic [2:0]        n_bytes;
   logic              last_beat;
   logic              misalign;
   logic              unused_rdata_hi;

   assign n_bytes         = size_bytes(size_r);
   assign last_beat       = (idx == n_bytes - 3'd1);
   assign unused_rdata_hi = ^bus.mem_rdata[DATA_W-1:LANE_W];

`ifdef MISALIGN_TRAP_EN
   logic err_r;
   assign misalign     = is_misaligned(bus.req_size, bus.req_addr[1:0]);
   assign bus.resp_err = (state == DONE) && err_r;
`else
   assign misalign     = 1'b0;
   assign bus.resp_err = 1'b0;
`endif

   load_extend #(.DATA_W(DATA_W)) u_load_extend (
      .word      (asm_r),
      .size      (size_r),
      .is_signed (signed_r),
      .ext       (ext_data)
   );

   always_ff @(posedge clk) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt         = state;
      bus.req_ready     = 1'b0;
      bus.resp_valid    = 1'b0;
      bus.resp_rdata    = '0;
      bus.MemoryAddress = '0;
      bus.memRD         = 1'b0;
      bus.memWD         = 1'b0;
      bus.mem_wdata     = '0;
      case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) state_nxt = misalign ? DONE : ACCESS;
         end
         ACCESS: begin
            bus.MemoryAddress = addr_r + ADDR_W'(idx);
            if (we_r) begin
               bus.memWD     = 1'b1;
               bus.mem_wdata = DATA_W'(wdata_r[int'(idx)*LANE_W +: LANE_W]);
            end else begin
               bus.memRD = 1'b1;
            end
            if (last_beat) state_nxt = we_r ? DONE : CAPTURE;
         end
         CAPTURE: state_nxt = DONE;
         DONE: begin
            bus.resp_valid = 1'b1;
            bus.resp_rdata = we_r ? '0 : ext_data;
            state_nxt      = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // Suppress strobes in the reset cycle so an aborted store never
      // commits the byte it was about to write.
      if (Reset) begin
         bus.memRD = 1'b0;
         bus.memWD = 1'b0;
      end
   end

   // Request latch, beat counter and read-byte assembly. The read port is
   // registered, so the byte requested at beat idx-1 arrives during beat idx;
   // the final byte lands during CAPTURE.
   always_ff @(posedge clk) begin
      if (Reset) begin
         idx   <= '0;
         asm_r <= '0;
`ifdef MISALIGN_TRAP_EN
         err_r <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  addr_r   <= bus.req_addr;
                  size_r   <= bus.req_size;
                  signed_r <= bus.req_signed;
                  we_r     <= bus.req_we;
                  wdata_r  <= bus.req_wdata;
                  idx      <= '0;
                  asm_r    <= '0;
`ifdef MISALIGN_TRAP_EN
                  err_r    <= misalign;
`endif
               end
            end
            ACCESS: begin
               if (!we_r && idx != 3'd0)
                  asm_r[(int'(idx)-1)*LANE_W +: LANE_W] <= bus.mem_rdata[LANE_W-1:0];
               idx <= idx + 3'd1;
            end
            CAPTURE: asm_r[(int'(n_bytes)-1)*LANE_W +: LANE_W] <= bus.mem_rdata[LANE_W-1:0];
            default: ;
         endcase
      end
   end

endmodule
